// File: rtl/riscv_v_arith_alu_sched_if.sv
// riscv_v_arith_alu_sched_if: requester, ALU-control and response signals of the ALU scheduler
interface riscv_v_arith_alu_sched_if #(parameter int NUM_REQ = 4, parameter int TAG_W = 4);
   localparam int IW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_is_mul;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       alu_sel;
   logic                     alu_busy;
   logic                     capture_en;
   logic                     rsp_valid;
   logic [IW-1:0]            rsp_id;
   logic [TAG_W-1:0]         rsp_tag;
   logic                     rsp_ready;
   modport master (output req_valid, req_is_mul, req_tag, rsp_ready,
                   input  req_ready, alu_sel, alu_busy, capture_en, rsp_valid, rsp_id, rsp_tag);
   modport slave  (input  req_valid, req_is_mul, req_tag, rsp_ready,
                   output req_ready, alu_sel, alu_busy, capture_en, rsp_valid, rsp_id, rsp_tag);
endinterface

// File: rtl/riscv_v_arith_alu_sched.sv
// riscv_v_arith_alu_sched: round-robin scheduler sharing one vector ALU among NUM_REQ requesters
module riscv_v_arith_alu_sched #(
   parameter int NUM_REQ = 4,
   parameter int MUL_LAT = 3,
   parameter int TAG_W   = 4
) (
   input logic clk,
   input logic rst,
   riscv_v_arith_alu_sched_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RSP} state_t;
   state_t             r_state, w_next;
   logic [IW-1:0]      r_ptr, r_id, r_rsp_id, w_gid;
   logic [CW-1:0]      r_cnt;
   logic [TAG_W-1:0]   r_tag, r_rsp_tag;
   logic [NUM_REQ-1:0] r_sel, w_gnt;
   logic               w_found, w_win, w_acc, w_done;
   // Grant window: IDLE, or RSP in the cycle the response is consumed
   assign w_win  = (r_state == S_IDLE) || (r_state == S_RSP && bus.rsp_ready);
   assign w_acc  = w_win && w_found;
   assign w_done = (r_state == S_EXEC) && (r_cnt == '0);
   always_comb begin
      w_gnt   = '0;
      w_gid   = '0;
      w_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_found = 1'b1;
            w_gid   = IW'((int'(r_ptr) + k) % NUM_REQ);
            w_gnt[(int'(r_ptr) + k) % NUM_REQ] = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_acc ? S_EXEC : S_IDLE;
         S_EXEC:  w_next = w_done ? S_RSP : S_EXEC;
         S_RSP:   w_next = bus.rsp_ready ? (w_acc ? S_EXEC : S_IDLE) : S_RSP;
         default: w_next = S_IDLE;
      endcase
   end
   always_comb begin
      bus.req_ready  = w_win ? w_gnt : '0;
      bus.alu_sel    = r_sel;
      bus.alu_busy   = (r_state == S_EXEC);
      bus.capture_en = w_done;
      bus.rsp_valid  = (r_state == S_RSP);
      bus.rsp_id     = r_rsp_id;
      bus.rsp_tag    = r_rsp_tag;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr     <= '0;
         r_sel     <= '0;
         r_id      <= '0;
         r_tag     <= '0;
         r_cnt     <= '0;
         r_rsp_id  <= '0;
         r_rsp_tag <= '0;
      end else begin
         if (w_acc) begin
            r_ptr <= IW'((int'(w_gid) + 1) % NUM_REQ);
            r_sel <= w_gnt;
            r_id  <= w_gid;
            r_tag <= bus.req_tag[int'(w_gid)*TAG_W +: TAG_W];
            r_cnt <= bus.req_is_mul[w_gid] ? CW'(MUL_LAT - 1) : '0;
         end else if (r_state == S_EXEC && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_done) begin
            r_rsp_id  <= r_id;
            r_rsp_tag <= r_tag;
         end
         if (r_state == S_RSP && bus.rsp_ready && !w_acc) r_sel <= '0;
      end
   end
endmodule

// File: tb/tb_riscv_v_arith_alu_sched.sv
// tb_riscv_v_arith_alu_sched: directed stimulus with a response scoreboard for the ALU scheduler
module tb_riscv_v_arith_alu_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [5:0] exp_q[$];
   riscv_v_arith_alu_sched_if #(.NUM_REQ(4), .TAG_W(4)) bus();
   riscv_v_arith_alu_sched #(.NUM_REQ(4), .MUL_LAT(3), .TAG_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic samp();
      @(negedge clk);
   endtask
   // Scoreboard monitor: every consumed response must match the oldest expected {id,tag}
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_unexpected: got id=%0d tag=%0h want none", bus.rsp_id, bus.rsp_tag);
         end else begin
            chk("rsp_id_tag", {26'd0, bus.rsp_id, bus.rsp_tag}, {26'd0, exp_q.pop_front()});
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.req_valid  = '0;
      bus.req_is_mul = '0;
      bus.req_tag    = '0;
      bus.rsp_ready  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.rsp_ready = i[0];
         samp();
         chk("reset_idle", {14'd0, bus.req_ready, bus.alu_sel, bus.alu_busy, bus.capture_en,
                            bus.rsp_valid, bus.rsp_id, bus.rsp_tag}, 32'd0);
         tick();
      end
      // Single non-mul op from requester 0
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b0001;
      bus.req_tag   = 16'h0005;
      samp();
      chk("single_ready", 32'(bus.req_ready), 32'b0001);
      exp_q.push_back({2'd0, 4'd5});
      tick();
      bus.req_valid = '0;
      samp();
      chk("single_exec", {29'd0, bus.alu_sel == 4'b0001, bus.capture_en, bus.alu_busy}, 32'b111);
      tick();
      samp();
      chk("single_rsp", {31'd0, bus.rsp_valid}, 32'd1);
      tick();
      samp();
      chk("single_rsp_gone", {30'd0, bus.rsp_valid, bus.alu_busy}, 32'd0);
      tick();
      // All four valid; rr_ptr is 1 after the previous grant
      bus.req_valid = 4'b1111;
      bus.req_tag   = 16'hDCBA;
      for (int k = 0; k < 8; k++) begin
         logic [1:0] g;
         logic [3:0] oh;
         g  = 2'((1 + k) % 4);
         oh = 4'b0001 << g;
         samp();
         chk("rr_grant", 32'(bus.req_ready), 32'(oh));
         exp_q.push_back({g, 4'(4'hA + 4'(g))});
         tick();
         if (k == 7) bus.req_valid = '0;
         samp();
         chk("rr_exec_noready", {27'd0, bus.req_ready, bus.capture_en}, 32'd1);
         tick();
      end
      tick();
      tick();
      // Multiply from requester 2, tag 9
      bus.req_valid  = 4'b0100;
      bus.req_is_mul = 4'b0100;
      bus.req_tag    = 16'h0900;
      samp();
      chk("mul_ready", 32'(bus.req_ready), 32'b0100);
      exp_q.push_back({2'd2, 4'd9});
      tick();
      bus.req_valid  = '0;
      bus.req_is_mul = '0;
      for (int c = 1; c <= 3; c++) begin
         samp();
         chk("mul_busy_cap", {30'd0, bus.alu_busy, bus.capture_en}, (c == 3) ? 32'b11 : 32'b10);
         tick();
      end
      samp();
      chk("mul_rsp", {30'd0, bus.rsp_valid, bus.alu_busy}, 32'b10);
      tick();
      samp();
      chk("mul_rsp_gone", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
      // Backpressure: rr_ptr is 3, so requester 0 wins, then requester 1
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0001;
      bus.req_tag   = 16'h0073;
      samp();
      chk("bp_grant0", 32'(bus.req_ready), 32'b0001);
      exp_q.push_back({2'd0, 4'd3});
      tick();
      bus.req_valid = 4'b0011;
      tick();
      for (int c = 0; c < 5; c++) begin
         samp();
         chk("bp_hold", {21'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.req_ready},
             {21'd0, 1'b1, 2'd0, 4'd3, 4'b0000});
         tick();
      end
      bus.rsp_ready = 1'b1;
      samp();
      chk("bp_release_grant", 32'(bus.req_ready), 32'b0010);
      exp_q.push_back({2'd1, 4'd7});
      tick();
      bus.req_valid = '0;
      tick();
      tick();
      samp();
      chk("bp_idle", {30'd0, bus.rsp_valid, bus.alu_busy}, 32'd0);
      tick();
      // Reset during mul EXEC; rr_ptr is 2 before the kill
      bus.req_valid  = 4'b0100;
      bus.req_is_mul = 4'b0100;
      bus.req_tag    = 16'h0600;
      samp();
      chk("kill_grant", 32'(bus.req_ready), 32'b0100);
      tick();
      bus.req_valid  = '0;
      bus.req_is_mul = '0;
      samp();
      chk("kill_busy", {31'd0, bus.alu_busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("kill_async", {21'd0, bus.alu_sel, bus.alu_busy, bus.capture_en, bus.rsp_valid,
                         bus.req_ready}, 32'd0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         samp();
         chk("kill_quiet", {29'd0, bus.rsp_valid, bus.capture_en, bus.alu_busy}, 32'd0);
         tick();
      end
      bus.req_valid = 4'b1001;
      bus.req_tag   = 16'h2001;
      samp();
      chk("post_reset_ptr0", 32'(bus.req_ready), 32'b0001);
      exp_q.push_back({2'd0, 4'd1});
      tick();
      bus.req_valid = '0;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/riscv_v_arith_alu_sched.md
Name: riscv_v_arith_alu_sched

Overview:
Round-robin scheduler that shares one vector arithmetic ALU between NUM_REQ issue requesters (e.g. per-lane or per-queue dispatchers).
- Accepts one operation at a time over a valid/ready handshake.
- Steers the ALU operand/control mux through a one-hot select.
- Times single-cycle and multi-cycle (multiply) operations.
- Returns a tagged response with backpressure.
- Sits between vector dispatch and the ALU interface's system side; the operand mux and result register live in the datapath and are controlled by this block.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
MUL_LAT, 3, ALU occupancy cycles for multiply ops (>=1)
TAG_W, 4, width of per-request tag carried to the response

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester operation valid
req_is_mul  in  NUM_REQ  per-requester op is multiply (uses MUL_LAT)
req_tag  in  NUM_REQ*TAG_W  per-requester tag, requester i at [i*TAG_W +: TAG_W]
req_ready  out  NUM_REQ  one-hot grant; accept when req_valid[i]&req_ready[i]
alu_sel  out  NUM_REQ  one-hot operand/control mux select, registered, valid while alu_busy
alu_busy  out  1  ALU occupied by granted op (EXEC state)
capture_en  out  1  one-cycle pulse: datapath registers ALU result/zf/of/cf this cycle
rsp_valid  out  1  response available
rsp_id  out  $clog2(NUM_REQ)  requester index of response
rsp_tag  out  TAG_W  tag of response
rsp_ready  in  1  response consumer ready

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=0, cnt=0.
  - alu_sel=0, alu_busy=0, capture_en=0, rsp_valid=0, rsp_id=0, rsp_tag=0, req_ready=0.
- States: IDLE, EXEC, RSP.
- Grant window:
  - Open in IDLE, or in RSP in the cycle rsp_ready=1 (response handshake).
  - Outside the window req_ready=0.
  - Within the window req_ready is combinational from registered rr_ptr and current req_valid.
  - The winner is the first asserted req_valid scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready has at most one bit set, and only for a valid requester.
- On accept (requester g):
  - rr_ptr <= (g+1) mod NUM_REQ.
  - alu_sel <= onehot(g); latch id=g, tag=req_tag[g], is_mul.
  - cnt <= (is_mul ? MUL_LAT : 1) - 1; state <= EXEC.
- EXEC:
  - alu_busy=1.
  - cnt>0: cnt decrements, capture_en=0.
  - cnt==0: capture_en=1 (combinational), next state RSP, rsp_valid<=1, rsp_id/rsp_tag <= latched values.
- RSP:
  - rsp_valid=1; alu_sel holds last value (don't care); alu_busy=0.
  - rsp_ready=0: hold all response outputs stable, no new grant.
  - rsp_ready=1 with a new accept: go to EXEC (back-to-back).
  - rsp_ready=1 without a new accept: rsp_valid<=0, alu_sel<=0, state IDLE.
- Latency: accept at cycle t; non-mul capture_en at t+1 and rsp_valid at t+2; mul capture_en at t+MUL_LAT and rsp_valid at t+MUL_LAT+1.
- Throughput:
  - Non-mul ops with rsp_ready tied high complete one per 2 cycles.
  - Mul ops complete one per MUL_LAT+1 cycles.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- rr_ptr only advances on accept; it does not move when no requester is valid.
- Requester changing req_valid without handshake: no effect on state; the grant is re-evaluated each cycle.
- Reset mid-EXEC/RSP: op is discarded, no capture_en/rsp_valid is produced, and no stale response appears after reset release.
- rsp_ready=1 while IDLE: ignored.

Test Plan:
- Reset, no requests -> all outputs 0 and state IDLE for 10 cycles; rsp_ready toggling causes no response.
- req_valid=4'b0001, tag0=5, non-mul, rsp_ready=1 -> req_ready=0001 at t; alu_sel=0001 and capture_en at t+1; rsp_valid, rsp_id=0, rsp_tag=5 at t+2 for one cycle.
- All four requesters valid continuously, non-mul, rsp_ready=1 -> grant order 0,1,2,3,0,1... with one grant every 2 cycles; tags returned in the same order.
- req 2 mul (MUL_LAT=3), tag=9 -> alu_busy for 3 cycles; capture_en only on the 3rd; rsp_valid at t+4 with rsp_id=2, rsp_tag=9.
- rsp_ready held low 5 cycles with requesters 0 and 1 valid -> rsp_valid, rsp_id and rsp_tag stable; req_ready=0; on rsp_ready=1 the next grant goes to the next rr requester in that same cycle.
- rst asserted during EXEC of a mul op -> outputs 0 immediately; after release, no response for the killed op; the next request is granted starting from rr_ptr=0.
